// File: rtl/line_buffer.sv
// ============================================================================
// Module  : line_buffer
// Purpose : Ping-pong scanline store; upstream fills one bank while vga reads
//           the other, banks swap every LINE_REPEAT displayed lines.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module line_buffer #(
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH       = 640,
  parameter int ADDR_WIDTH  = 13,
  parameter int LINE_REPEAT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic                  line_request,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  line_finished,
  output logic                  underrun
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam logic [CW-1:0]         c_last_word = CW'(DEPTH - 1);
  localparam logic [RW-1:0]         c_last_rep  = RW'(LINE_REPEAT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_depth_a   = ADDR_WIDTH'(DEPTH);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                state_q;
  logic                  read_bank_q;
  logic                  ready_q;
  logic                  line_request_q;
  logic                  underrun_q;
  logic                  in_reset_q;
  logic [CW-1:0]         write_count_q;
  logic [RW-1:0]         repeat_count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] bank0_q [DEPTH];
  logic [DATA_WIDTH-1:0] bank1_q [DEPTH];

  logic w_transfer;
  logic w_last_xfer;
  logic w_full_d;
  logic w_swap_point;
  logic w_swap;

  // A final write landing on the swap point still counts as a complete line.
  assign w_transfer   = pixel_valid && ready_q && !reset;
  assign w_last_xfer  = w_transfer && (write_count_q == c_last_word);
  assign w_full_d     = (state_q == FULL) || w_last_xfer;
  assign w_swap_point = line_finished && (repeat_count_q == c_last_rep);
  assign w_swap       = w_swap_point && w_full_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= FILL;
      read_bank_q    <= 1'b0;
      write_count_q  <= '0;
      repeat_count_q <= '0;
      ready_q        <= 1'b0;
      line_request_q <= 1'b0;
      underrun_q     <= 1'b0;
      in_reset_q     <= 1'b1;
    end else begin
      in_reset_q     <= 1'b0;
      line_request_q <= in_reset_q || w_swap;
      underrun_q     <= w_swap_point && !w_full_d && !in_reset_q;

      if (w_swap) begin
        read_bank_q   <= ~read_bank_q;
        write_count_q <= '0;
        state_q       <= FILL;
        ready_q       <= 1'b1;
      end else begin
        ready_q <= !w_full_d;
        if (w_last_xfer) begin
          state_q <= FULL;
        end else if (w_transfer) begin
          write_count_q <= write_count_q + 1'b1;
        end
      end

      if (line_finished) begin
        if (repeat_count_q == c_last_rep) begin
          repeat_count_q <= '0;
        end else begin
          repeat_count_q <= repeat_count_q + 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; only the write bank is ever written.
  always_ff @(posedge clock) begin
    if (w_transfer) begin
      if (read_bank_q) begin
        bank0_q[write_count_q] <= pixel_data;
      end else begin
        bank1_q[write_count_q] <= pixel_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else if (address >= c_depth_a) begin
      data_q <= '0;
    end else if (read_bank_q) begin
      data_q <= bank1_q[address[CW-1:0]];
    end else begin
      data_q <= bank0_q[address[CW-1:0]];
    end
  end

  assign pixel_ready  = ready_q;
  assign line_request = line_request_q;
  assign underrun     = underrun_q;
  assign data         = data_q;

endmodule

`default_nettype wire

// File: tb/tb_line_buffer.sv
// ============================================================================
// Module  : tb_line_buffer
// Purpose : Self-checking bench for line_buffer (DEPTH=4, LINE_REPEAT=2).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_line_buffer;

  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int AW    = 13;
  localparam int REP   = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pixel_data = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic          line_request;
  logic [AW-1:0] address = 13'd7;
  logic [DW-1:0] data;
  logic          line_finished = 1'b0;
  logic          underrun;

  int checks = 0;
  int errors = 0;

  line_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .LINE_REPEAT(REP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .line_request (line_request),
    .address      (address),
    .data         (data),
    .line_finished(line_finished),
    .underrun     (underrun)
  );

  always #5 clock = ~clock;

  // Reference model: the line being collected is a queue; a swap hands the
  // whole completed line to the display side.
  logic [DW-1:0] m_mem [2][DEPTH];
  bit            m_known [2][DEPTH];
  logic [DW-1:0] m_line [$];
  int            m_rb = 0;
  int            m_rep = 0;
  bit            m_rdy = 0, m_lrq = 0, m_und = 0, m_was_rst = 0, m_dknown = 0;
  logic [DW-1:0] m_data = '0;

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            lf;
    logic [AW-1:0] a;
    bit            rdy;
    bit            lrq;
    bit            und;
    logic [DW-1:0] q;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit lf,
                            input logic [AW-1:0] a, input bit r);
    if (r) begin
      m_rb = 0; m_line.delete(); m_rep = 0;
      m_rdy = 0; m_lrq = 0; m_und = 0;
      m_data = '0; m_dknown = 1; m_was_rst = 1;
      return;
    end
    m_lrq = m_was_rst;
    m_und = 0;
    m_was_rst = 0;
    if (a < DEPTH) begin
      m_dknown = m_known[m_rb][a];
      m_data   = m_mem[m_rb][a];
    end else begin
      m_dknown = 1;
      m_data   = '0;
    end
    if (v && m_rdy) begin
      m_mem[1-m_rb][m_line.size()]   = d;
      m_known[1-m_rb][m_line.size()] = 1;
      m_line.push_back(d);
    end
    if (lf) begin
      if (m_rep == REP - 1) begin
        m_rep = 0;
        if (m_line.size() == DEPTH) begin
          m_rb = 1 - m_rb;
          m_line.delete();
          m_lrq = 1;
        end else begin
          m_und = 1;
        end
      end else begin
        m_rep++;
      end
    end
    m_rdy = (m_line.size() < DEPTH);
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit lf,
                      input logic [AW-1:0] a, input bit r);
    pixel_valid = v; pixel_data = d; line_finished = lf; address = a; reset = r;
    @(posedge clock);
    #1;
    model_step(v, d, lf, a, r);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".ready"}, pixel_ready, m_rdy);
    check({tag, ".line_request"}, line_request, m_lrq);
    check({tag, ".underrun"}, underrun, m_und);
    if (m_dknown) check({tag, ".data"}, data, m_data);
  endtask

  task automatic addv(input bit v, input logic [DW-1:0] d, input bit lf, input logic [AW-1:0] a,
                      input bit rdy, input bit lrq, input bit und, input logic [DW-1:0] q);
    vec_t e;
    e.v = v; e.d = d; e.lf = lf; e.a = a; e.rdy = rdy; e.lrq = lrq; e.und = und; e.q = q;
    tbl.push_back(e);
  endtask

  initial begin
    // Each row: inputs for one cycle, then outputs expected after that edge.
    // fill
    addv(1, 12'h111, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h222, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h333, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h444, 0, 7, 0, 0, 0, 12'h000);
    // swap after second line_finished, then read back
    addv(0, 12'h000, 1, 7, 0, 0, 0, 12'h000);
    addv(0, 12'h000, 1, 7, 1, 1, 0, 12'h000);
    addv(0, 12'h000, 0, 0, 1, 0, 0, 12'h111);
    addv(0, 12'h000, 0, 1, 1, 0, 0, 12'h222);
    addv(0, 12'h000, 0, 2, 1, 0, 0, 12'h333);
    addv(0, 12'h000, 0, 3, 1, 0, 0, 12'h444);
    // underrun: half line at swap point
    addv(1, 12'h555, 0, 0, 1, 0, 0, 12'h111);
    addv(1, 12'h666, 0, 1, 1, 0, 0, 12'h222);
    addv(0, 12'h000, 1, 2, 1, 0, 0, 12'h333);
    addv(0, 12'h000, 1, 3, 1, 0, 1, 12'h444);
    addv(0, 12'h000, 0, 0, 1, 0, 0, 12'h111);
    addv(1, 12'h777, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h888, 0, 7, 0, 0, 0, 12'h000);
    addv(0, 12'h000, 1, 7, 0, 0, 0, 12'h000);
    addv(0, 12'h000, 1, 7, 1, 1, 0, 12'h000);
    addv(0, 12'h000, 0, 0, 1, 0, 0, 12'h555);
    addv(0, 12'h000, 0, 1, 1, 0, 0, 12'h666);
    addv(0, 12'h000, 0, 2, 1, 0, 0, 12'h777);
    addv(0, 12'h000, 0, 3, 1, 0, 0, 12'h888);
    // final write coincides with swap point
    addv(1, 12'haaa, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'hbbb, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'hccc, 1, 7, 1, 0, 0, 12'h000);
    addv(1, 12'hddd, 1, 7, 1, 1, 0, 12'h000);
    addv(0, 12'h000, 0, 3, 1, 0, 0, 12'hddd);
    addv(0, 12'h000, 0, 0, 1, 0, 0, 12'haaa);
    // handshake stall with junk data on invalid cycles
    addv(1, 12'h001, 0, 7, 1, 0, 0, 12'h000);
    addv(0, 12'h0ff, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h002, 0, 7, 1, 0, 0, 12'h000);
    addv(0, 12'h0fe, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h003, 0, 7, 1, 0, 0, 12'h000);
    addv(0, 12'h0fd, 0, 7, 1, 0, 0, 12'h000);
    addv(1, 12'h004, 0, 7, 0, 0, 0, 12'h000);
    addv(0, 12'h000, 1, 7, 0, 0, 0, 12'h000);
    addv(0, 12'h000, 1, 7, 1, 1, 0, 12'h000);
    addv(0, 12'h000, 0, 0, 1, 0, 0, 12'h001);
    addv(0, 12'h000, 0, 1, 1, 0, 0, 12'h002);
    addv(0, 12'h000, 0, 2, 1, 0, 0, 12'h003);
    addv(0, 12'h000, 0, 3, 1, 0, 0, 12'h004);
    addv(0, 12'h000, 0, 5, 1, 0, 0, 12'h000);

    // reset and release
    step(0, '0, 0, 7, 1);
    step(0, '0, 0, 7, 1);
    check("rst.ready", pixel_ready, 1'b0);
    check("rst.line_request", line_request, 1'b0);
    check("rst.underrun", underrun, 1'b0);
    check("rst.data", data, 12'h000);
    step(0, '0, 0, 7, 0);
    check("rel.line_request", line_request, 1'b1);
    check("rel.ready", pixel_ready, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].lf, tbl[i].a, 1'b0);
      check($sformatf("vec%0d.ready", i), pixel_ready, tbl[i].rdy);
      check($sformatf("vec%0d.line_request", i), line_request, tbl[i].lrq);
      check($sformatf("vec%0d.underrun", i), underrun, tbl[i].und);
      check($sformatf("vec%0d.data", i), data, tbl[i].q);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) == 0,
           AW'($urandom_range(0, 6)), 1'b0);
      compare_model("rand");
    end

    // mid-line reset
    step(1, 12'he01, 0, 7, 0);
    compare_model("mlr.w1");
    step(1, 12'he02, 0, 7, 0);
    compare_model("mlr.w2");
    step(0, '0, 0, 0, 1);
    check("mlr.rst.data", data, 12'h000);
    check("mlr.rst.ready", pixel_ready, 1'b0);
    check("mlr.rst.line_request", line_request, 1'b0);
    step(0, '0, 0, 0, 0);
    check("mlr.rel.line_request", line_request, 1'b1);
    check("mlr.rel.ready", pixel_ready, 1'b1);
    compare_model("mlr.rel");
    for (int i = 0; i < DEPTH; i++) begin
      step(1, DW'(12'he11 + i), 0, 7, 0);
      compare_model("mlr.fill");
    end
    check("mlr.full.ready", pixel_ready, 1'b0);
    step(0, '0, 1, 7, 0);
    compare_model("mlr.lf1");
    step(0, '0, 1, 7, 0);
    check("mlr.swap.line_request", line_request, 1'b1);
    compare_model("mlr.lf2");
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 0, AW'(i), 0);
      check($sformatf("mlr.read%0d", i), data, DW'(12'he11 + i));
      compare_model("mlr.read");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_buffer.md
# line_buffer

Double-buffered (ping-pong) scanline store between the pixel source (frame fetch / host write path) and the `vga` output stage. Upstream fills one bank with the next scanline over a valid/ready handshake, while `vga` reads the other bank by address with 1-cycle latency. Banks swap on `vga`'s `line_finished` pulse once every `LINE_REPEAT` displayed lines, which implements line doubling. The block reports when upstream failed to deliver a complete line in time.

## Interface
Parameters:
- `DATA_WIDTH`, 12, pixel width, RGB444 packed {r,g,b}.
- `DEPTH`, 640, words per bank (pixels per displayed line).
- `ADDR_WIDTH`, 13, read address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `LINE_REPEAT`, 2, displayed lines per stored line (>=1).

Ports:
- `clock`  in  1  single system/pixel clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pixel_data`  in  DATA_WIDTH  write-side pixel.
- `pixel_valid`  in  1  upstream has `pixel_data`.
- `pixel_ready`  out  1  block accepts a pixel this cycle.
- `line_request`  out  1  1-cycle pulse: write bank empty, send next line.
- `address`  in  ADDR_WIDTH  read address from `vga`.
- `data`  out  DATA_WIDTH  registered read data.
- `line_finished`  in  1  1-cycle pulse from `vga` at end of each displayed line.
- `underrun`  out  1  1-cycle pulse: swap due but write bank incomplete.

## Operation
- Storage: two banks of DEPTH x DATA_WIDTH. `read_bank` bit selects the display bank; the write bank is always `~read_bank`.
- Write FSM states:
  - FILL: `pixel_ready`=1. A transfer occurs when `pixel_valid && pixel_ready`. It stores the pixel at write_bank[write_count] and increments `write_count`. The transfer with write_count==DEPTH-1 moves to FULL.
  - FULL: `pixel_ready`=0. Waits for a swap.
- `pixel_ready` is a function of state only and never depends on `pixel_valid`.
- Repeat counter `repeat_count` runs 0..LINE_REPEAT-1 and advances on each `line_finished`.
- On `line_finished` with repeat_count==LINE_REPEAT-1 (swap point):
  - `repeat_count` is set to 0.
  - If FULL: toggle `read_bank`, clear `write_count`, go to FILL, pulse `line_request` next cycle.
  - If not FULL: no swap, so the display repeats the old line. Pulse `underrun` next cycle. `write_count` and FILL progress are kept, and the line keeps filling toward the next swap point.
- On `line_finished` not at the swap point: `repeat_count` increments and nothing else changes.
- Simultaneous final write transfer and swap point in the same cycle: the write is committed and the buffer counts as FULL, so the swap happens. The display bank then contains that final pixel.
- Read: `data <= bank[read_bank][address]` every cycle. If address >= DEPTH, `data <= 0`. A bank toggle takes effect for reads in the cycle after `line_finished`.
- Writes never touch the display bank, so read and write never collide.

## Timing
- Reset values: `read_bank`=0, `write_count`=0, state FILL, `repeat_count`=0, `data`=0, `underrun`=0. `line_request`=0 during reset, then one pulse in the first cycle after reset deasserts. `pixel_ready`=0 while `reset` is high and 1 from the first cycle after.
- Memory contents are not cleared by reset.
- Reset mid-line discards the partial write line and returns everything to reset state.
- Read latency: exactly 1 cycle from `address` to `data`.
- Write throughput: 1 pixel/cycle, so a full line needs DEPTH cycles minimum.
- `line_request` and `underrun` are registered, exactly 1 cycle wide, and never asserted in the same cycle.
- Back-to-back `line_finished` pulses on consecutive cycles are each counted.

## Test plan
Bench uses DEPTH=4, LINE_REPEAT=2.
- Reset release: `line_request` pulses once in cycle 1 after reset and `pixel_ready`=1. Write 0x111,0x222,0x333,0x444 -> `pixel_ready`=0 after the 4th transfer.
- Swap: after the fill above, send two `line_finished` pulses -> swap after the 2nd. Read addresses 0..3 -> `data` = 0x111..0x444, each one cycle later. `line_request` pulses and `pixel_ready` returns to 1.
- Underrun: write only 2 pixels, then two `line_finished` -> `underrun` pulses once and there is no swap; reads still return the previous line. Write 2 more pixels and two more `line_finished` -> swap occurs and the new line is readable.
- Coincidence: 4th write transfer in the same cycle as the 2nd `line_finished` -> swap occurs, no `underrun`, address 3 reads the 4th pixel.
- Handshake stall: `pixel_valid` toggles 1,0,1,0,... -> only valid cycles are stored, in order, with no duplicates. Address 5 reads 0.
- Mid-line reset: after 2 writes, assert `reset` for 1 cycle -> `data`=0, `read_bank`=0, `write_count`=0, `line_request` pulses after release, and 4 fresh writes plus 2 `line_finished` read back correctly.
